// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial N-bit subtractor computing dif = a - b, LSB first, one bit per
// clock, through a single full-subtractor stage whose borrow is held in a
// flip-flop. Operands and result are exchanged through a start/done
// handshake: a start seen in IDLE captures a and b, N RUN cycles process
// one bit each, and a one-cycle DONE state presents the result.
//
// Ports
//   clk    in   1  clock, all state updates on the rising edge
//   reset  in   1  synchronous, active-high reset (priority over everything)
//   start  in   1  request, sampled only in IDLE
//   a      in   N  minuend, captured on an accepted start
//   b      in   N  subtrahend, captured on an accepted start
//   busy   out  1  high in RUN and DONE
//   done   out  1  one-cycle pulse, result valid
//   dif    out  N  a - b modulo 2^N, held until the next result completes
//   rout   out  1  final borrow, 1 iff unsigned a < b
//   ovf    out  1  two's-complement overflow of a - b
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] dif,
    output logic         rout,
    output logic         ovf
);

    localparam int CNT_W = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    logic [1:0]       state_q,  state_d;
    logic [N-1:0]     a_q,      a_d;
    logic [N-1:0]     b_q,      b_d;
    logic [N-1:0]     res_q,    res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [N-1:0]     dif_q,    dif_d;
    logic             rout_q,   rout_d;
    logic             ovf_q,    ovf_d;

    // Full-subtractor stage on the current LSBs.
    logic x, y, d_bit, bout;

    assign x     = a_q[0];
    assign y     = b_q[0];
    assign d_bit = x ^ y ^ borrow_q;
    assign bout  = (~x & y) | (~(x ^ y) & borrow_q);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no
        // path through the case statement can leave one unassigned (no latch).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        dif_d    = dif_q;
        rout_d   = rout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = {d_bit, res_q[N-1:1]};
                borrow_d = bout;
                if (cnt_q == LAST_BIT) begin
                    // Last bit: publish the result and flags in one step so
                    // the outputs only ever change on the RUN->DONE edge.
                    dif_d   = {d_bit, res_q[N-1:1]};
                    rout_d  = bout;
                    // Operand signs differ and the result sign differs from
                    // the minuend: the signed result left the range.
                    ovf_d   = (x ^ y) & (x ^ d_bit);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            dif_q    <= '0;
            rout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            dif_q    <= dif_d;
            rout_q   <= rout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_DONE);
    assign done = (state_q == S_DONE);
    assign dif  = dif_q;
    assign rout = rout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Drives an 8-bit and a 4-bit serial_subtractor. Expected results come from
// plain integer arithmetic: dif = (a - b) mod 2^N, rout = (a < b), and ovf
// from the signed difference leaving the N-bit two's-complement range.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset;

    logic       start8, busy8, done8, rout8, ovf8;
    logic [7:0] a8, b8, dif8;

    logic       start4, busy4, done4, rout4, ovf4;
    logic [3:0] a4, b4, dif4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .dif   (dif8),
        .rout  (rout8),
        .ovf   (ovf8)
    );

    serial_subtractor #(.N(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .dif   (dif4),
        .rout  (rout4),
        .ovf   (ovf4)
    );

    // Output view of whichever instance the current operation targets.
    logic        sel4 = 1'b0;
    logic        busy_s, done_s, rout_s, ovf_s;
    logic [31:0] dif_s;

    assign busy_s = sel4 ? busy4 : busy8;
    assign done_s = sel4 ? done4 : done8;
    assign rout_s = sel4 ? rout4 : rout8;
    assign ovf_s  = sel4 ? ovf4  : ovf8;
    assign dif_s  = sel4 ? {28'd0, dif4} : {24'd0, dif8};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic definition of subtraction.
    function automatic void ref_sub(input int n, input int av, input int bv,
                                    output logic [31:0] d, output logic r,
                                    output logic o);
        int half;
        int sa;
        int sb;
        int diff;
        half = 1 << (n - 1);
        d    = 32'((av - bv) & ((1 << n) - 1));
        r    = (av < bv);
        sa   = (av >= half) ? av - (1 << n) : av;
        sb   = (bv >= half) ? bv - (1 << n) : bv;
        diff = sa - sb;
        o    = (diff < -half) || (diff > half - 1);
    endfunction

    // One full handshake starting from an IDLE falling edge; operands are
    // scrambled during RUN to show they were captured at acceptance.
    task automatic do_op(input logic use4, input logic [7:0] av, input logic [7:0] bv);
        int          n;
        int          k;
        logic        got;
        logic [31:0] exp_d;
        logic        exp_r;
        logic        exp_o;

        n    = use4 ? 4 : 8;
        sel4 = use4;
        ref_sub(n, use4 ? int'(av[3:0]) : int'(av), use4 ? int'(bv[3:0]) : int'(bv),
                exp_d, exp_r, exp_o);

        if (use4) begin
            start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0];
        end else begin
            start8 = 1'b1; a8 = av; b8 = bv;
        end
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        check("busy_after_accept", {31'd0, busy_s}, 32'd1);

        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            @(posedge clk);
            @(negedge clk);
            k++;
            if (done_s) got = 1'b1;
        end
        check("latency", k, n);
        check("dif", dif_s, exp_d);
        check("rout", {31'd0, rout_s}, {31'd0, exp_r});
        check("ovf", {31'd0, ovf_s}, {31'd0, exp_o});
        check("busy_in_done", {31'd0, busy_s}, 32'd1);

        @(posedge clk);
        @(negedge clk);
        check("done_pulse_width", {31'd0, done_s}, 32'd0);
        check("busy_idle", {31'd0, busy_s}, 32'd0);
        check("dif_hold", dif_s, exp_d);
    endtask

    localparam int P8 = 10;  // N+2 cycles per operation with start held high

    logic [7:0] hold_a [3] = '{8'h5A, 8'h03, 8'hC4};
    logic [7:0] hold_b [3] = '{8'hA5, 8'h70, 8'h44};

    initial begin
        logic [31:0] exp_d;
        logic        exp_r;
        logic        exp_o;

        reset  = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_dif", {24'd0, dif8}, 32'd0);
        check("rst_rout", {31'd0, rout8}, 32'd0);
        check("rst_ovf", {31'd0, ovf8}, 32'd0);
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        check("rst_dif4", {28'd0, dif4}, 32'd0);

        // Directed 8-bit cases, with literal expectations as well.
        do_op(1'b0, 8'd5, 8'd3);
        check("lit_5_3_dif", {24'd0, dif8}, 32'h02);
        check("lit_5_3_rout", {31'd0, rout8}, 32'd0);
        do_op(1'b0, 8'd3, 8'd5);
        check("lit_3_5_dif", {24'd0, dif8}, 32'hFE);
        check("lit_3_5_rout", {31'd0, rout8}, 32'd1);
        check("lit_3_5_ovf", {31'd0, ovf8}, 32'd0);
        do_op(1'b0, 8'h80, 8'h01);
        check("lit_80_01_dif", {24'd0, dif8}, 32'h7F);
        check("lit_80_01_ovf", {31'd0, ovf8}, 32'd1);
        do_op(1'b0, 8'h7F, 8'hFF);
        do_op(1'b0, 8'h00, 8'h00);

        // Random 8-bit operands.
        for (int i = 0; i < 20; i++) begin
            do_op(1'b0, 8'($urandom), 8'($urandom));
        end

        // start held high, operands scrambled outside the IDLE edges.
        sel4 = 1'b0;
        for (int c = 0; c < 3 * P8; c++) begin
            if (c % P8 == 0) begin
                a8 = hold_a[c / P8];
                b8 = hold_b[c / P8];
            end else begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            start8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("held_done", {31'd0, done8}, {31'd0, 1'((c % P8) == 8)});
            check("held_busy", {31'd0, busy8}, {31'd0, 1'((c % P8) != P8 - 1)});
            if (c % P8 == 8) begin
                ref_sub(8, int'(hold_a[c / P8]), int'(hold_b[c / P8]), exp_d, exp_r, exp_o);
                check("held_dif", {24'd0, dif8}, exp_d);
                check("held_rout", {31'd0, rout8}, {31'd0, exp_r});
                check("held_ovf", {31'd0, ovf8}, {31'd0, exp_o});
            end
        end
        start8 = 1'b0;

        // Reset in the middle of an operation, with a nonzero result held.
        do_op(1'b0, 8'h10, 8'h01);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_dif", {24'd0, dif8}, 32'd0);
        check("abort_rout", {31'd0, rout8}, 32'd0);
        do_op(1'b0, 8'hFF, 8'hFF);
        check("ff_ff_dif", {24'd0, dif8}, 32'd0);
        check("ff_ff_rout", {31'd0, rout8}, 32'd0);
        check("ff_ff_ovf", {31'd0, ovf8}, 32'd0);

        // Every 4-bit operand pair.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_op(1'b1, 8'(i), 8'(j));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
